alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 16-bit ALU family. It takes a W-bit operand pair, carry-in and 3-bit opcode through a valid/ready input port and returns a registered W-bit result with zero, negative, carry and overflow flags. Single-cycle operations produce a result one cycle after acceptance. Multiply is a multi-cycle iterative shift-add. It is the ALU datapath slice of the sequential core and replaces direct instantiation of the combinational ALUs.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU slice.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Ceiling log2, usable in constant expressions (shift-amount and counter widths).
  function automatic int clog2_fn(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operand port and registered result port of alu_seq.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int W = 16
);

  logic         in_valid;
  logic         in_ready;
  opc_t         opc;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] w;
  logic         zer;
  logic         neg;
  logic         cout;
  logic         ovf;

  // Producer/consumer side: issues operations and takes results.
  modport master (
    output in_valid, opc, A, B, C, out_ready,
    input  in_ready, out_valid, w, zer, neg, cout, ovf
  );

  // ALU side.
  modport slave (
    input  in_valid, opc, A, B, C, out_ready,
    output in_ready, out_valid, w, zer, neg, cout, ovf
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: W iterations, low W bits of unsigned a*b.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = clog2_fn(W);

  logic         busy;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] prod;
  logic [CW-1:0] count;

  // p is the product after the current iteration; on the last one it is final.
  assign p    = mplier[0] ? prod + mcand : prod;
  assign done = busy && (count == CW'(W - 1));

  // Load operands on start, then one shift-add step per cycle until done.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // blocking = here would let later lines see already-updated state.
    if (rst) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
      count  <= '0;
    end else if (busy) begin
      prod   <= p;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish in one cycle, MUL iterates W cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int SHW = clog2_fn(W);

  alu_state_t   state;
  alu_state_t   state_next;
  logic         accept;
  logic         start_mul;
  logic         mul_done;
  logic [W-1:0] mul_p;

  logic [W-1:0] b_eff;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] alu_w;
  logic         alu_cout;
  logic         alu_ovf;

  logic [W-1:0] w_q;
  logic         cout_q;
  logic         ovf_q;

  assign accept    = bus.in_ready & bus.in_valid;
  assign start_mul = accept & (bus.opc == OP_MUL);

  alu_mul_iter #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (start_mul),
    .a     (bus.A),
    .b     (bus.B),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Single-cycle datapath; SUB reuses the adder as A + ~B + !C.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    alu_w    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    b_eff    = (bus.opc == OP_SUB) ? ~bus.B : bus.B;
    cin      = (bus.opc == OP_SUB) ? ~bus.C : bus.C;
    sum      = {1'b0, bus.A} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    case (bus.opc)
      OP_ADD, OP_SUB: begin
        alu_w    = sum[W-1:0];
        alu_cout = sum[W];
        alu_ovf  = (bus.A[W-1] == b_eff[W-1]) && (sum[W-1] != bus.A[W-1]);
      end
      OP_AND:  alu_w = bus.A & bus.B;
      OP_OR:   alu_w = bus.A | bus.B;
      OP_XOR:  alu_w = bus.A ^ bus.B;
      OP_SHL:  alu_w = bus.A << bus.B[SHW-1:0];
      OP_SRA:  alu_w = $signed(bus.A) >>> bus.B[SHW-1:0];
      default: alu_w = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE with out_ready accepts a new op in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) state_next = (bus.opc == OP_MUL) ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (mul_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_next = (bus.opc == OP_MUL) ? ST_BUSY : ST_DONE;
          else              state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready depends only on state and out_ready.
  always_comb begin
    bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
    bus.out_valid = (state == ST_DONE);
  end

  // Result register: loaded on single-cycle accept or on the last MUL step.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept && (bus.opc != OP_MUL)) begin
      w_q    <= alu_w;
      cout_q <= alu_cout;
      ovf_q  <= alu_ovf;
    end else if ((state == ST_BUSY) && mul_done) begin
      w_q    <= mul_p;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end
  end

  assign bus.w    = w_q;
  assign bus.zer  = (w_q == '0);
  assign bus.neg  = w_q[W-1];
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=16, plus W=8/W=32 back-to-back.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_seq_if #(.W(16)) bus16 ();
  alu_seq_if #(.W(8))  bus8  ();
  alu_seq_if #(.W(32)) bus32 ();

  alu_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  alu_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  alu_seq #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input opc_t op, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus16.in_valid = 1'b1;
    bus16.opc      = op;
    bus16.A        = a;
    bus16.B        = b;
    bus16.C        = c;
  endtask

  // Flags packed as {zer, neg, cout, ovf}.
  function automatic logic [3:0] flags16();
    return {bus16.zer, bus16.neg, bus16.cout, bus16.ovf};
  endfunction

  // Accept a MUL from idle and measure its latency and in_ready during BUSY.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_w);
    int cycles;
    int ready_seen;
    drive16(OP_MUL, a, b, 1'b0);
    tick();
    bus16.in_valid = 1'b0;
    bus16.A = 16'h5a5a;
    bus16.B = 16'ha5a5;
    cycles = 0;
    ready_seen = 0;
    while (!bus16.out_valid && cycles < 40) begin
      if (bus16.in_ready) ready_seen++;
      tick();
      cycles++;
    end
    check({tag, "_latency"}, cycles, 16);
    check({tag, "_in_ready_busy"}, ready_seen, 0);
    check({tag, "_w"}, bus16.w, exp_w);
    check({tag, "_cout_ovf"}, {bus16.cout, bus16.ovf}, 2'b00);
    tick();
  endtask

  // Independent reference: {zer, neg, cout, ovf} in [35:32], result in [31:0].
  function automatic logic [35:0] model(input int wd, input logic [2:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in,
                                        input logic c);
    logic [63:0] mask, a, b, bb, s, r;
    logic        cy, ov, sa;
    int          sh;
    mask = (64'd1 << wd) - 64'd1;
    a  = a_in & mask;
    b  = b_in & mask;
    sh = int'(b % 64'(wd));
    cy = 1'b0;
    ov = 1'b0;
    sa = a[wd-1];
    r  = '0;
    case (op)
      3'd0, 3'd1: begin
        bb = (op == 3'd1) ? (~b & mask) : b;
        s  = a + bb + ((op == 3'd1) ? 64'(!c) : 64'(c));
        r  = s & mask;
        cy = s[wd];
        ov = (sa == bb[wd-1]) && (r[wd-1] != sa);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a << sh) & mask;
      3'd6: begin
        r = a >> sh;
        if (sa) r = r | (mask & ~(mask >> sh));
      end
      default: r = (a * b) & mask;
    endcase
    return {(r == 64'd0), r[wd-1], cy, ov, r[31:0]};
  endfunction

  initial begin
    int stable_bad;
    int spurious;
    logic [35:0] exp8, exp32;

    n_cmp = 0;
    n_bad = 0;
    vecs = '{
      '{3'd0, 32'h8000_00F0, 32'h8000_0020, 1'b1},
      '{3'd1, 32'h0000_0010, 32'h0000_0020, 1'b1},
      '{3'd2, 32'hF0F0_A5C3, 32'h0FF0_FF0F, 1'b0},
      '{3'd3, 32'h1234_0005, 32'h0000_80A0, 1'b0},
      '{3'd4, 32'hAAAA_55FF, 32'hFFFF_0F0F, 1'b1},
      '{3'd5, 32'h0001_0081, 32'h0000_0025, 1'b0},
      '{3'd6, 32'h8000_0090, 32'h0000_0004, 1'b0},
      '{3'd0, 32'h7FFF_FF7F, 32'h0000_0001, 1'b0},
      '{3'd1, 32'h8000_0080, 32'h0000_0001, 1'b0},
      '{3'd6, 32'h4000_0070, 32'h0000_0023, 1'b1}
    };

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.opc = OP_ADD; bus16.A = '0; bus16.B = '0; bus16.C = 1'b0;
    bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.opc  = OP_ADD; bus8.A  = '0; bus8.B  = '0; bus8.C  = 1'b0;
    bus8.out_ready  = 1'b1;
    bus32.in_valid = 1'b0; bus32.opc = OP_ADD; bus32.A = '0; bus32.B = '0; bus32.C = 1'b0;
    bus32.out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_out_valid", bus16.out_valid, 1'b0);
    check("rst_w", bus16.w, 16'h0000);
    check("rst_flags", flags16(), 4'b1000);
    check("rst_in_ready", bus16.in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // ADD with carry out and zero result; latency 1.
    bus16.out_ready = 1'b1;
    drive16(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    check("add0_in_ready", bus16.in_ready, 1'b1);
    tick();
    bus16.in_valid = 1'b0;
    check("add0_out_valid", bus16.out_valid, 1'b1);
    check("add0_w", bus16.w, 16'h0000);
    check("add0_flags", flags16(), 4'b1010);

    // SUB with borrow, accepted from DONE.
    drive16(OP_SUB, 16'h0005, 16'h0007, 1'b0);
    tick();
    check("sub_w", bus16.w, 16'hFFFE);
    check("sub_flags", flags16(), 4'b0100);

    // ADD signed overflow, back-to-back.
    drive16(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    tick();
    bus16.in_valid = 1'b0;
    check("add_ovf_out_valid", bus16.out_valid, 1'b1);
    check("add_ovf_w", bus16.w, 16'h8000);
    check("add_ovf_flags", flags16(), 4'b0101);
    tick();
    check("idle_out_valid", bus16.out_valid, 1'b0);

    // Multiplies.
    run_mul("mul0", 16'h0123, 16'h0010, 16'h1230);
    run_mul("mul1", 16'hFFFF, 16'hFFFF, 16'h0001);

    // Backpressure: SRA result held while a queued XOR waits.
    bus16.out_ready = 1'b0;
    drive16(OP_SRA, 16'h8000, 16'h0003, 1'b0);
    tick();
    drive16(OP_XOR, 16'h00FF, 16'h0F0F, 1'b1);
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 ||
          bus16.w !== 16'hF000 || flags16() !== 4'b0100) stable_bad++;
      tick();
    end
    check("bp_stable_cycles_bad", stable_bad, 0);
    check("bp_w", bus16.w, 16'hF000);
    check("bp_flags", flags16(), 4'b0100);
    bus16.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", bus16.in_ready, 1'b1);
    tick();
    bus16.in_valid = 1'b0;
    check("bp_queued_out_valid", bus16.out_valid, 1'b1);
    check("bp_queued_w", bus16.w, 16'h0FF0);
    tick();

    // Reset during BUSY cycle 8: no MUL result may appear afterwards.
    drive16(OP_MUL, 16'h0003, 16'h0005, 1'b0);
    tick();
    bus16.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("rmul_busy_in_ready", bus16.in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmul_out_valid", bus16.out_valid, 1'b0);
    check("rmul_w", bus16.w, 16'h0000);
    check("rmul_zer", bus16.zer, 1'b1);
    check("rmul_in_ready", bus16.in_ready, 1'b1);
    spurious = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus16.out_valid) spurious++;
    end
    check("rmul_no_result", spurious, 0);

    // Back-to-back single-cycle ops at W=8 and W=32, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      bus8.in_valid  = 1'b1;
      bus8.opc       = opc_t'(vecs[i].op);
      bus8.A         = vecs[i].a[7:0];
      bus8.B         = vecs[i].b[7:0];
      bus8.C         = vecs[i].c;
      bus32.in_valid = 1'b1;
      bus32.opc      = opc_t'(vecs[i].op);
      bus32.A        = vecs[i].a;
      bus32.B        = vecs[i].b;
      bus32.C        = vecs[i].c;
      exp8  = model(8,  vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].c);
      exp32 = model(32, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].c);
      check($sformatf("b2b8_ready_%0d", i), bus8.in_ready, 1'b1);
      tick();
      check($sformatf("b2b8_%0d", i),
            {bus8.out_valid, bus8.zer, bus8.neg, bus8.cout, bus8.ovf, bus8.w},
            {1'b1, exp8[35:32], exp8[7:0]});
      check($sformatf("b2b32_%0d", i),
            {bus32.out_valid, bus32.zer, bus32.neg, bus32.cout, bus32.ovf, bus32.w},
            {1'b1, exp32[35:32], exp32[31:0]});
    end
    bus8.in_valid  = 1'b0;
    bus32.in_valid = 1'b0;
    tick();
    check("b2b_drain", {bus8.out_valid, bus32.out_valid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
